// File: rtl/kt_seg_pkg.sv
// Shared 7-segment constants for the kitchen-timer display driver and its capture monitor.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: active-low {g,f,e,d,c,b,a} digit patterns, decoded code values, digit type.
package kt_seg_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decoded values that are not BCD digits.
  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_INVALID = 4'hE;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Decodes one active-low 7-segment pattern back to its BCD digit code.
// Latency: combinational.
// Backpressure: none.
// Ports: seg[6:0] {g..a} active-low in; code[3:0] out (0-9, F=blank, E=unknown); invalid out.
module seg7_to_bcd
  import kt_seg_pkg::*;
(
  input  logic [6:0] seg,
  output bcd_t       code,
  output logic       invalid
);

  always_comb begin
    code    = CODE_INVALID;
    invalid = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a scanned 4-digit 7-segment display (cathode/AN) and republishes it as BCD frames.
// Latency: pin change -> pending after SYNC_STAGES+SETTLE_CYCLES edges; frame 1 edge after 4th slot.
// Backpressure: none; free-running monitor, frame_valid is a pulse that must be taken when seen.
// Ports: clk, rst_n (async, active-low); cathode[6:0], AN[3:0] active-low pins;
//        digits[15:0] {d3,d2,d1,d0}, frame_valid, seg_err, an_err pulses; display_off level.
module seg_scan_capture
  import kt_seg_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int OFF_TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  cathode,
  input  logic [3:0]  AN,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        an_err,
  output logic        display_off
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW = $clog2(OFF_TIMEOUT + 1);

  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_ONE = SW'(1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(OFF_TIMEOUT);
  localparam logic [IW-1:0] IDLE_ONE   = IW'(1);

  // {AN, cathode} travel through the synchronizer as one 11-bit word.
  logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;
  logic [10:0]                  prev_q, prev_d;
  logic [SW-1:0]                settle_q, settle_d;
  logic [IW-1:0]                idle_q, idle_d;
  logic [NUM_DIGITS-1:0]        mask_q, mask_d;
  bcd_t [NUM_DIGITS-1:0]        pending_q, pending_d;
  logic [15:0]                  digits_q, digits_d;
  logic                         frame_valid_q, frame_valid_d;
  logic                         seg_err_q, seg_err_d;
  logic                         an_err_q, an_err_d;

  logic [10:0] samp;
  logic [3:0]  an_s;
  logic [6:0]  cath_s;
  logic        changed;
  logic        accept;
  logic        an_idle;
  logic        an_one_hot;
  logic        an_multi;
  logic        publish;
  bcd_t        dec_code;
  logic        dec_invalid;

  assign samp   = sync_q[SYNC_STAGES-1];
  assign an_s   = samp[10:7];
  assign cath_s = samp[6:0];

  seg7_to_bcd u_dec (
    .seg     (cath_s),
    .code    (dec_code),
    .invalid (dec_invalid)
  );

  // Synchronizer chain: stage 0 takes the pins, each later stage the one before.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {AN, cathode};
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Dwell detection. The counter saturates, so an accept happens on the single
  // edge where it first reaches SETTLE_CYCLES; a held pattern is accepted once.
  // A change sample reloads to 1, which for SETTLE_CYCLES==1 is itself the accept.
  always_comb begin
    changed = (samp != prev_q);
    prev_d  = samp;
    if (changed) begin
      settle_d = SETTLE_ONE;
    end else if (settle_q == SETTLE_MAX) begin
      settle_d = settle_q;
    end else begin
      settle_d = settle_q + SETTLE_ONE;
    end
    accept = (settle_d == SETTLE_MAX) && (changed || (settle_q != SETTLE_MAX));
  end

  // Anode classification of the synced sample.
  always_comb begin
    an_idle    = (an_s == 4'hF);
    an_one_hot = ($countones(~an_s) == 1);
    an_multi   = !an_idle && !an_one_hot;
  end

  // Idle counter runs on raw synced AN, not on accepts, so any lit digit
  // (even a glitch) restarts the blank-display timeout.
  always_comb begin
    if (!an_idle) begin
      idle_d = '0;
    end else if (idle_q == IDLE_MAX) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + IDLE_ONE;
    end
  end

  // Frame assembly. Publishing and the idle discard both clear the mask first;
  // a capture on the same edge then lands in the fresh mask for the next frame.
  always_comb begin
    publish   = (mask_q == 4'hF);
    mask_d    = mask_q;
    pending_d = pending_q;
    digits_d  = digits_q;

    if (publish) begin
      digits_d = pending_q;
      mask_d   = '0;
    end
    if (idle_q == IDLE_MAX) begin
      mask_d = '0;
    end

    if (accept && an_one_hot) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!an_s[i]) begin
          pending_d[i] = dec_code;
          mask_d[i]    = 1'b1;
        end
      end
    end

    frame_valid_d = publish;
    seg_err_d     = accept && dec_invalid;
    an_err_d      = accept && an_multi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '1;
      prev_q        <= '1;
      settle_q      <= '0;
      idle_q        <= '0;
      mask_q        <= '0;
      pending_q     <= '1;
      digits_q      <= 16'hFFFF;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      an_err_q      <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      settle_q      <= settle_d;
      idle_q        <= idle_d;
      mask_q        <= mask_d;
      pending_q     <= pending_d;
      digits_q      <= digits_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      an_err_q      <= an_err_d;
    end
  end

  assign digits      = digits_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign an_err      = an_err_q;
  assign display_off = (idle_q == IDLE_MAX);

endmodule

// File: tb/tb_seg_scan_capture.sv
`timescale 1ns/1ps
module tb_seg_scan_capture;

  localparam int SYNC   = 2;
  localparam int SETTLE = 4;
  localparam int OFF    = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  cathode;
  logic [3:0]  AN;
  logic [15:0] digits;
  logic        frame_valid, seg_err, an_err, display_off;

  always #5 clk = ~clk;

  seg_scan_capture #(
    .SYNC_STAGES   (SYNC),
    .SETTLE_CYCLES (SETTLE),
    .OFF_TIMEOUT   (OFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cathode     (cathode),
    .AN          (AN),
    .digits      (digits),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .an_err      (an_err),
    .display_off (display_off)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: pin and synced-sample histories plus frame contents.
  logic [10:0] pins[$];
  logic [10:0] hist[$];
  logic [3:0]  m_mask;
  logic [3:0]  m_pend[4];
  logic [15:0] m_digits;
  logic        e_fv, e_seg, e_an, e_off;
  int          exp_fv, exp_seg, exp_an;
  int          obs_fv, obs_seg, obs_an;
  int          cyc_mis;
  time         first_mis_t;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b1000000;
      1: pat = 7'b1111001;
      2: pat = 7'b0100100;
      3: pat = 7'b0110000;
      4: pat = 7'b0011001;
      5: pat = 7'b0010010;
      6: pat = 7'b0000010;
      7: pat = 7'b1111000;
      8: pat = 7'b0000000;
      9: pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
  endfunction

  // Returns {invalid, code}.
  function automatic logic [4:0] ref_decode(input logic [6:0] c);
    if (c == 7'h7F) return {1'b0, 4'hF};
    for (int d = 0; d < 10; d++) begin
      if (pat(d) == c) return {1'b0, 4'(d)};
    end
    return {1'b1, 4'hE};
  endfunction

  // Number of most recent synced samples with every anode off, capped at OFF.
  function automatic int trailing_idle();
    int c = 0;
    for (int j = hist.size() - 1; j >= 0 && c < OFF; j--) begin
      if (hist[j][10:7] == 4'hF) c++;
      else break;
    end
    return c;
  endfunction

  // Advance the model by one clock edge on which the pins held 'pin'.
  task automatic model_edge(input logic [10:0] pin);
    logic [10:0] s;
    logic [4:0]  dec;
    logic [3:0]  nm;
    int          run, idle_prev, idle_now, zeros;
    logic        acc;
    idle_prev = trailing_idle();
    pins.push_back(pin);
    if (pins.size() > 8) void'(pins.pop_front());
    s = (pins.size() > SYNC) ? pins[pins.size() - 1 - SYNC] : 11'h7FF;
    hist.push_back(s);
    if (hist.size() > 40) void'(hist.pop_front());
    run = 0;
    for (int j = hist.size() - 1; j >= 0 && run <= SETTLE; j--) begin
      if (hist[j] == s) run++;
      else break;
    end
    acc      = (run == SETTLE);
    idle_now = trailing_idle();
    dec      = ref_decode(s[6:0]);
    zeros    = 0;
    for (int i = 0; i < 4; i++) if (!s[7+i]) zeros++;

    e_fv = (m_mask == 4'hF);
    nm   = (e_fv || idle_prev >= OFF) ? 4'h0 : m_mask;
    if (e_fv) m_digits = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
    if (acc && zeros == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (!s[7+i]) begin
          m_pend[i] = dec[3:0];
          nm[i]     = 1'b1;
        end
      end
    end
    m_mask = nm;
    e_seg  = acc && dec[4];
    e_an   = acc && (zeros > 1);
    e_off  = (idle_now >= OFF);
    if (e_fv)  exp_fv++;
    if (e_seg) exp_seg++;
    if (e_an)  exp_an++;
  endtask

  task automatic clear_counts();
    exp_fv = 0; exp_seg = 0; exp_an = 0;
    obs_fv = 0; obs_seg = 0; obs_an = 0;
    cyc_mis = 0; first_mis_t = 0;
  endtask

  // Called at a negedge; drives pins for one cycle and records DUT vs model.
  task automatic step(input logic [3:0] an, input logic [6:0] cath);
    AN      = an;
    cathode = cath;
    @(posedge clk);
    model_edge({an, cath});
    #1;
    if (frame_valid === 1'b1) obs_fv++;
    if (seg_err === 1'b1)     obs_seg++;
    if (an_err === 1'b1)      obs_an++;
    if (frame_valid !== e_fv || seg_err !== e_seg || an_err !== e_an ||
        display_off !== e_off || digits !== m_digits) begin
      if (cyc_mis == 0) first_mis_t = $time;
      cyc_mis++;
    end
    @(negedge clk);
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] cath, input int len);
    for (int k = 0; k < len; k++) step(an, cath);
  endtask

  task automatic scan_slot(input int slot, input int d, input int len);
    logic [3:0] a;
    a = 4'hF;
    a[slot] = 1'b0;
    dwell(a, pat(d), len);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    AN      = 4'hF;
    cathode = 7'h7F;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pins.delete();
    hist.delete();
    m_mask   = 4'h0;
    for (int i = 0; i < 4; i++) m_pend[i] = 4'hF;
    m_digits = 16'hFFFF;
    e_fv = 1'b0; e_seg = 1'b0; e_an = 1'b0; e_off = 1'b0;
    clear_counts();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_assert++; if (digits !== 16'hFFFF) begin n_fail++; $display("FAIL reset_digits: got %h expected %h", digits, 16'hFFFF); end
    n_assert++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
    n_assert++; if (seg_err !== 1'b0) begin n_fail++; $display("FAIL reset_seg_err: got %b expected 0", seg_err); end
    n_assert++; if (an_err !== 1'b0) begin n_fail++; $display("FAIL reset_an_err: got %b expected 0", an_err); end
    n_assert++; if (display_off !== 1'b0) begin n_fail++; $display("FAIL reset_display_off: got %b expected 0", display_off); end
  endtask

  task automatic test_scan_basic();
    do_reset();
    for (int i = 0; i < 4; i++) scan_slot(i, i + 1, 8);
    dwell(4'hF, 7'h7F, 8);
    n_assert++; if (obs_fv !== 1) begin n_fail++; $display("FAIL basic_frame_count: got %0d expected 1", obs_fv); end
    n_assert++; if (digits !== 16'h4321) begin n_fail++; $display("FAIL basic_digits: got %h expected 4321", digits); end
    n_assert++; if (obs_seg + obs_an !== 0) begin n_fail++; $display("FAIL basic_err_pulses: got %0d expected 0", obs_seg + obs_an); end
    n_assert++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL basic_cycle_model: %0d cycles differ, first at %0t, expected 0", cyc_mis, first_mis_t); end
  endtask

  task automatic test_glitch();
    int pre, d1, d2, d3;
    do_reset();
    pre = $urandom_range(1, 5);
    d1 = $urandom_range(0, 9); d2 = $urandom_range(0, 9); d3 = $urandom_range(0, 9);
    dwell(4'b1110, pat(0), pre);
    dwell(4'b1110, pat(8), 2);
    dwell(4'b1110, pat(0), 10 - pre);
    scan_slot(1, d1, 8); scan_slot(2, d2, 8); scan_slot(3, d3, 8);
    dwell(4'hF, 7'h7F, 8);
    n_assert++; if (digits[3:0] !== 4'h0) begin n_fail++; $display("FAIL glitch_digit0: got %h expected 0", digits[3:0]); end
    n_assert++; if (digits !== {4'(d3), 4'(d2), 4'(d1), 4'h0}) begin n_fail++; $display("FAIL glitch_digits: got %h expected %h", digits, {4'(d3), 4'(d2), 4'(d1), 4'h0}); end
    n_assert++; if (obs_fv !== 1) begin n_fail++; $display("FAIL glitch_frame_count: got %0d expected 1", obs_fv); end
    n_assert++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL glitch_cycle_model: %0d cycles differ, first at %0t, expected 0", cyc_mis, first_mis_t); end
  endtask

  task automatic test_bad_segment();
    int d0, d2, d3;
    do_reset();
    d0 = $urandom_range(0, 9); d2 = $urandom_range(0, 9); d3 = $urandom_range(0, 9);
    scan_slot(0, d0, 8);
    dwell(4'b1101, 7'b0101010, 8);
    scan_slot(2, d2, 8); scan_slot(3, d3, 8);
    dwell(4'hF, 7'h7F, 8);
    n_assert++; if (obs_seg !== 1) begin n_fail++; $display("FAIL badseg_pulses: got %0d expected 1", obs_seg); end
    n_assert++; if (digits !== {4'(d3), 4'(d2), 4'hE, 4'(d0)}) begin n_fail++; $display("FAIL badseg_digits: got %h expected %h", digits, {4'(d3), 4'(d2), 4'hE, 4'(d0)}); end
    n_assert++; if (obs_fv !== 1) begin n_fail++; $display("FAIL badseg_frame_count: got %0d expected 1", obs_fv); end
    n_assert++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL badseg_cycle_model: %0d cycles differ, first at %0t, expected 0", cyc_mis, first_mis_t); end
  endtask

  task automatic test_an_err();
    int d0, dx;
    do_reset();
    d0 = $urandom_range(0, 9);
    dx = (d0 + 1 + $urandom_range(0, 8)) % 10;
    scan_slot(0, d0, 8);
    dwell(4'b1100, pat(dx), 8);
    n_assert++; if (obs_an !== 1) begin n_fail++; $display("FAIL anerr_pulses: got %0d expected 1", obs_an); end
    n_assert++; if (obs_fv !== 0) begin n_fail++; $display("FAIL anerr_no_frame: got %0d expected 0", obs_fv); end
    for (int i = 1; i < 4; i++) scan_slot(i, $urandom_range(0, 9), 8);
    dwell(4'hF, 7'h7F, 8);
    n_assert++; if (obs_fv !== 1) begin n_fail++; $display("FAIL anerr_mask_kept: got %0d frames expected 1", obs_fv); end
    n_assert++; if (digits[3:0] !== 4'(d0)) begin n_fail++; $display("FAIL anerr_slot0_kept: got %h expected %h", digits[3:0], 4'(d0)); end
    n_assert++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL anerr_cycle_model: %0d cycles differ, first at %0t, expected 0", cyc_mis, first_mis_t); end
  endtask

  task automatic test_idle();
    int a[4], c[4];
    logic [15:0] first;
    do_reset();
    for (int i = 0; i < 4; i++) begin a[i] = $urandom_range(0, 9); c[i] = $urandom_range(0, 9); end
    first = {4'(a[3]), 4'(a[2]), 4'(a[1]), 4'(a[0])};
    for (int i = 0; i < 4; i++) scan_slot(i, a[i], 8);
    dwell(4'hF, 7'h7F, 4);
    scan_slot(0, $urandom_range(0, 9), 8);
    scan_slot(1, $urandom_range(0, 9), 8);
    dwell(4'hF, 7'h7F, 17);
    n_assert++; if (display_off !== 1'b0) begin n_fail++; $display("FAIL idle_off_at_15: got %b expected 0", display_off); end
    step(4'hF, 7'h7F);
    n_assert++; if (display_off !== 1'b1) begin n_fail++; $display("FAIL idle_off_at_16: got %b expected 1", display_off); end
    dwell(4'hF, 7'h7F, 2);
    n_assert++; if (digits !== first) begin n_fail++; $display("FAIL idle_digits_hold: got %h expected %h", digits, first); end
    scan_slot(2, c[2], 8);
    scan_slot(3, c[3], 8);
    n_assert++; if (display_off !== 1'b0) begin n_fail++; $display("FAIL idle_off_clears: got %b expected 0", display_off); end
    n_assert++; if (obs_fv !== 1) begin n_fail++; $display("FAIL idle_partial_dropped: got %0d frames expected 1", obs_fv); end
    scan_slot(0, c[0], 8);
    scan_slot(1, c[1], 8);
    dwell(4'hF, 7'h7F, 4);
    n_assert++; if (digits !== {4'(c[3]), 4'(c[2]), 4'(c[1]), 4'(c[0])}) begin n_fail++; $display("FAIL idle_resume_digits: got %h expected %h", digits, {4'(c[3]), 4'(c[2]), 4'(c[1]), 4'(c[0])}); end
    n_assert++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL idle_cycle_model: %0d cycles differ, first at %0t, expected 0", cyc_mis, first_mis_t); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int i = 0; i < 4; i++) scan_slot(i, $urandom_range(0, 9), 8);
    for (int i = 0; i < 3; i++) scan_slot(i, $urandom_range(0, 9), 8);
    #2;
    rst_n = 1'b0;
    do_reset();
    scan_slot(3, $urandom_range(0, 9), 8);
    dwell(4'hF, 7'h7F, 8);
    n_assert++; if (obs_fv !== 0) begin n_fail++; $display("FAIL rstmid_no_frame: got %0d expected 0", obs_fv); end
    n_assert++; if (digits !== 16'hFFFF) begin n_fail++; $display("FAIL rstmid_digits: got %h expected FFFF", digits); end
    n_assert++; if (obs_seg + obs_an !== 0) begin n_fail++; $display("FAIL rstmid_err_pulses: got %0d expected 0", obs_seg + obs_an); end
    n_assert++; if (display_off !== 1'b0) begin n_fail++; $display("FAIL rstmid_display_off: got %b expected 0", display_off); end
    n_assert++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL rstmid_cycle_model: %0d cycles differ, first at %0t, expected 0", cyc_mis, first_mis_t); end
  endtask

  task automatic test_back_to_back();
    int d[4];
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) begin
        d[i] = $urandom_range(0, 9);
        scan_slot(i, d[i], SETTLE);
      end
    end
    dwell(4'hF, 7'h7F, 8);
    n_assert++; if (obs_fv !== 3) begin n_fail++; $display("FAIL b2b_frame_count: got %0d expected 3", obs_fv); end
    n_assert++; if (digits !== {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])}) begin n_fail++; $display("FAIL b2b_digits: got %h expected %h", digits, {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])}); end
    n_assert++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL b2b_cycle_model: %0d cycles differ, first at %0t, expected 0", cyc_mis, first_mis_t); end
  endtask

  task automatic test_random_scan();
    logic [3:0] a;
    logic [6:0] c;
    int r;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        a = 4'hF;
        a[$urandom_range(0, 3)] = 1'b0;
      end else if (r < 75) begin
        a = 4'hF;
      end else begin
        a = 4'($urandom_range(0, 15));
        if ($countones(~a) < 2) a = 4'b0101;
      end
      r = $urandom_range(0, 99);
      if (r < 80)      c = pat($urandom_range(0, 9));
      else if (r < 90) c = 7'h7F;
      else             c = 7'($urandom);
      dwell(a, c, $urandom_range(1, 9));
    end
    dwell(4'hF, 7'h7F, 8);
    n_assert++; if (obs_fv !== exp_fv) begin n_fail++; $display("FAIL rand_frames: got %0d expected %0d", obs_fv, exp_fv); end
    n_assert++; if (obs_seg !== exp_seg) begin n_fail++; $display("FAIL rand_seg_err: got %0d expected %0d", obs_seg, exp_seg); end
    n_assert++; if (obs_an !== exp_an) begin n_fail++; $display("FAIL rand_an_err: got %0d expected %0d", obs_an, exp_an); end
    n_assert++; if (digits !== m_digits) begin n_fail++; $display("FAIL rand_digits: got %h expected %h", digits, m_digits); end
    n_assert++; if (cyc_mis !== 0) begin n_fail++; $display("FAIL rand_cycle_model: %0d cycles differ, first at %0t, expected 0", cyc_mis, first_mis_t); end
  endtask

  initial begin
    rst_n   = 1'b0;
    AN      = 4'hF;
    cathode = 7'h7F;
    test_reset();
    test_scan_basic();
    test_glitch();
    test_bad_segment();
    test_an_err();
    test_idle();
    test_reset_mid_frame();
    test_back_to_back();
    test_random_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
